// File: rtl/rom_loader.sv
// rom_loader: packs a little-endian byte stream into data_width words and
// writes them to consecutive memory addresses starting at a latched base.
module rom_loader #(
  parameter int data_width = 16,
  parameter int addr_width = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [addr_width-1:0] base_addr_i,
  input  logic [addr_width:0]   word_count_i,
  input  logic [7:0]            byte_i,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  output logic                  mem_we_o,
  output logic [addr_width-1:0] mem_addr_o,
  output logic [data_width-1:0] mem_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o
);

  localparam int NB = data_width / 8;
  localparam int LW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [LW-1:0]         LAST_LANE = LW'(NB - 1);
  localparam logic [addr_width+1:0] LIMIT     = {2'b01, {addr_width{1'b0}}};
  localparam logic [addr_width:0]   ONE_WORD  = {{addr_width{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [LW-1:0]         r_lane;
  logic [data_width-1:0] r_asm;
  logic [data_width-1:0] w_asm_nxt;
  logic [addr_width-1:0] r_addr;
  logic [addr_width:0]   r_remaining;
  logic [addr_width-1:0] r_mem_addr;
  logic [data_width-1:0] r_mem_data;
  logic                  r_error;
  logic [addr_width+1:0] w_end;
  logic                  w_range_err;
  logic                  w_start;
  logic                  w_xfer;
  logic                  w_last_byte;

  // Range end computed two bits wider so base+count can never overflow.
  assign w_end       = {2'b00, base_addr_i} + {1'b0, word_count_i};
  assign w_range_err = w_end > LIMIT;
  assign w_start     = (r_state == IDLE) && start_i;
  assign w_xfer      = byte_valid_i && byte_ready_o;
  assign w_last_byte = w_xfer && (r_lane == LAST_LANE);

  always_comb begin
    w_asm_nxt = r_asm;
    for (int i = 0; i < NB; i++) begin
      if (r_lane == LW'(i)) w_asm_nxt[8*i +: 8] = byte_i;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    byte_ready_o = 1'b0;
    mem_we_o     = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start_i) begin
          if (w_range_err || (word_count_i == '0)) w_state_nxt = DONE;
          else                                       w_state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        byte_ready_o = 1'b1;
        busy_o       = 1'b1;
        if (w_last_byte) w_state_nxt = WRITE;
      end
      WRITE: begin
        mem_we_o    = 1'b1;
        busy_o      = 1'b1;
        w_state_nxt = (r_remaining == ONE_WORD) ? DONE : COLLECT;
      end
      DONE: begin
        done_o      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_lane      <= '0;
      r_asm       <= '0;
      r_addr      <= '0;
      r_remaining <= '0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
      r_error     <= 1'b0;
    end else begin
      if (w_start) begin
        r_addr      <= base_addr_i;
        r_remaining <= word_count_i;
        r_error     <= w_range_err;
        r_lane      <= '0;
      end
      if (w_xfer) begin
        r_asm  <= w_asm_nxt;
        r_lane <= w_last_byte ? '0 : r_lane + 1'b1;
      end
      // Output word/address are captured here so they hold outside WRITE.
      if (w_last_byte) begin
        r_mem_addr <= r_addr;
        r_mem_data <= w_asm_nxt;
      end
      if (mem_we_o) begin
        r_addr      <= r_addr + 1'b1;
        r_remaining <= r_remaining - 1'b1;
      end
    end
  end

  assign mem_addr_o = r_mem_addr;
  assign mem_data_o = r_mem_data;
  assign error_o    = r_error;

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: random byte streams against a word-list reference of the
// expected memory writes, plus directed reset and start-while-busy cases.
module tb_rom_loader;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int CW = AW + 1;
  localparam int NB = DW / 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [AW-1:0] base_addr_i;
  logic [AW:0]   word_count_i;
  logic [7:0]    byte_i;
  logic          byte_valid_i;
  logic          byte_ready_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o;
  logic          busy_o;
  logic          done_o;
  logic          error_o;

  int total = 0;
  int bad = 0;
  logic [7:0] src_q[$];

  rom_loader #(.data_width(DW), .addr_width(AW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .base_addr_i(base_addr_i),
    .word_count_i(word_count_i), .byte_i(byte_i), .byte_valid_i(byte_valid_i),
    .byte_ready_o(byte_ready_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ready"}, byte_ready_o, 0);
    check_eq({tag, "_we"},    mem_we_o, 0);
    check_eq({tag, "_addr"},  mem_addr_o, 0);
    check_eq({tag, "_data"},  mem_data_o, 0);
    check_eq({tag, "_busy"},  busy_o, 0);
    check_eq({tag, "_done"},  done_o, 0);
    check_eq({tag, "_err"},   error_o, 0);
  endtask

  // Expected writes: word i = bytes NB*i..NB*i+NB-1 little-endian at base+i.
  task automatic run_load(input int base, input int cnt, input int dens, input bit busy_start);
    bit err;
    int nw, idx, wr, cyc;
    bit done_seen, exp_we, exp_done, word_done;
    logic [DW-1:0] exp_word;
    err = (base + cnt) > DEPTH;
    nw = err ? 0 : cnt;
    while (src_q.size() < nw * NB) src_q.push_back(8'($urandom));
    @(negedge clk);
    start_i = 1'b1;
    base_addr_i = AW'(base);
    word_count_i = CW'(cnt);
    byte_valid_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    base_addr_i = AW'($urandom);
    word_count_i = CW'($urandom);
    if (nw == 0) begin
      check_eq("done_early", done_o, 1);
      check_eq("err_flag", error_o, err);
      check_eq("busy_idle", busy_o, 0);
      check_eq("we_none", mem_we_o, 0);
      @(negedge clk);
      check_eq("done_once", done_o, 0);
      check_eq("err_sticky", error_o, err);
      check_eq("we_none2", mem_we_o, 0);
      src_q.delete();
      return;
    end
    check_eq("busy_start", busy_o, 1);
    check_eq("err_clear", error_o, 0);
    check_eq("done_not_early", done_o, 0);
    idx = 0; wr = 0; cyc = 0;
    done_seen = 0; exp_we = 0; exp_done = 0;
    while (!done_seen && cyc < 500) begin
      if (mem_we_o || exp_we) check_eq("we_timing", mem_we_o, exp_we);
      if (mem_we_o) begin
        exp_word = '0;
        if (wr < nw)
          for (int j = 0; j < NB; j++) exp_word[8*j +: 8] = src_q[wr*NB + j];
        check_eq("wr_addr", mem_addr_o, base + wr);
        check_eq("wr_data", mem_data_o, exp_word);
        check_eq("ready_in_write", byte_ready_o, 0);
        wr++;
      end
      if (done_o || exp_done) begin
        check_eq("done_timing", done_o, exp_done);
        done_seen = 1;
      end
      exp_done = mem_we_o && (wr == nw);
      if (!done_seen) begin
        start_i = 1'b0;
        if (busy_start && cyc == 3) begin
          start_i = 1'b1;
          base_addr_i = AW'(base + 5);
          word_count_i = CW'(1);
        end
        byte_valid_i = ($urandom_range(0, 99) < dens);
        byte_i = (byte_valid_i && idx < nw * NB) ? src_q[idx] : 8'($urandom);
        word_done = byte_valid_i && byte_ready_o && ((idx % NB) == NB - 1);
        if (byte_valid_i && byte_ready_o) idx++;
        exp_we = word_done;
        @(negedge clk);
        cyc++;
      end
    end
    byte_valid_i = 1'b0;
    start_i = 1'b0;
    check_eq("done_seen", done_seen, 1);
    check_eq("write_count", wr, nw);
    check_eq("bytes_used", idx, nw * NB);
    check_eq("err_at_done", error_o, 0);
    @(negedge clk);
    check_eq("done_pulse", done_o, 0);
    check_eq("busy_end", busy_o, 0);
    src_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    start_i = 1'b0;
    base_addr_i = '0;
    word_count_i = '0;
    byte_i = '0;
    byte_valid_i = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // basic load with fixed bytes, valid held high
    src_q = {8'h34, 8'h12, 8'h78, 8'h56};
    run_load(2, 2, 100, 1'b0);
    // zero count
    run_load(5, 0, 100, 1'b0);
    // range error, then legal load reaching the top address
    run_load(14, 3, 100, 1'b0);
    run_load(14, 2, 70, 1'b0);
    // full-array load from 0 is legal
    run_load(0, 16, 90, 1'b0);
    // stalled stream
    run_load(0, 6, 35, 1'b0);
    // start while busy is ignored
    run_load(1, 4, 80, 1'b1);

    // reset after the first byte of a word
    @(negedge clk);
    start_i = 1'b1; base_addr_i = AW'(3); word_count_i = CW'(2);
    @(negedge clk);
    start_i = 1'b0;
    check_eq("rst_pre_ready", byte_ready_o, 1);
    byte_valid_i = 1'b1; byte_i = 8'hAA;
    @(negedge clk);
    byte_valid_i = 1'b0;
    check_eq("rst_pre_busy", busy_o, 1);
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_no_write", mem_we_o, 0);
      check_eq("rst_idle", busy_o, 0);
    end
    src_q = {8'h5A, 8'hC3};
    run_load(3, 1, 100, 1'b0);

    repeat (12) begin
      run_load($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH),
               $urandom_range(20, 100), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
